pcie_tx_mrd_sched: RTL

Schedules memory-read requests from three DMA requesters onto the single MRd channel of the PCIe TX arbiter (the `tx_mrd*` inputs of `pcie_tx`). It arbitrates round-robin and allocates a PCIe tag from a bounded pool. It gates issue on non-posted header credit (`pcie_tfc_nph_av`) and releases tags when the RX path reports final completion. Requesters receive the allocated tag with their acknowledge so they can route completions.

---
 rtl/pcie_tx_mrd_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pcie_tx_mrd_sched.sv
// pcie_tx_mrd_sched: round-robin MRd scheduler with tag pool and NPH credit gating.
// Optional stall watchdog enabled by defining PCIE_TX_MRD_SCHED_TIMEOUT_EN.
`default_nettype none

module pcie_tx_mrd_sched #(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int C_TAG_NUM         = 16,
  parameter int C_TIMEOUT_CYCLES  = 1024
) (
  input  logic                           pcie_user_clk,
  input  logic                           pcie_user_rst,
  input  logic                           mrd0_req,
  input  logic [12:2]                    mrd0_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]   mrd0_addr,
  output logic                           mrd0_ack,
  input  logic                           mrd1_req,
  input  logic [12:2]                    mrd1_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]   mrd1_addr,
  output logic                           mrd1_ack,
  input  logic                           mrd2_req,
  input  logic [12:2]                    mrd2_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]   mrd2_addr,
  output logic                           mrd2_ack,
  output logic [7:0]                     mrd_ack_tag,
  output logic                           tx_mrd_req,
  output logic [7:0]                     tx_mrd_tag,
  output logic [12:2]                    tx_mrd_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2]   tx_mrd_addr,
  input  logic                           tx_mrd_req_ack,
  input  logic [1:0]                     pcie_tfc_nph_av,
  input  logic                           cpl_done,
  input  logic [7:0]                     cpl_done_tag,
  output logic [5:0]                     tag_free_cnt,
  output logic                           tag_err,
  output logic                           issue_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                         state;
  logic [C_TAG_NUM-1:0]           tag_busy;
  logic [1:0]                     rr_ptr;
  logic [1:0]                     winner;
  logic [2:0]                     ack_vec;

  logic [2:0]                     req_vec;
  logic [1:0]                     pick;
  logic                           alloc;
  logic [4:0]                     free_idx;
  logic [C_TAG_NUM-1:0]           alloc_vec;
  logic [C_TAG_NUM-1:0]           rel_vec;
  logic                           rel_valid;
  logic [12:2]                    win_len;
  logic [C_PCIE_ADDR_WIDTH-1:2]   win_addr;

  assign req_vec   = {mrd2_req, mrd1_req, mrd0_req};
  assign alloc     = (state == S_IDLE) && (|req_vec) && (tag_free_cnt != 6'd0) &&
                     (pcie_tfc_nph_av != 2'd0);
  assign rel_valid = |rel_vec;

  assign mrd0_ack = ack_vec[0];
  assign mrd1_ack = ack_vec[1];
  assign mrd2_ack = ack_vec[2];

  // Round-robin search starting at rr_ptr.
  always_comb begin
    pick = 2'd0;
    case (rr_ptr)
      2'd1: begin
        if (req_vec[1])      pick = 2'd1;
        else if (req_vec[2]) pick = 2'd2;
        else                 pick = 2'd0;
      end
      2'd2: begin
        if (req_vec[2])      pick = 2'd2;
        else if (req_vec[0]) pick = 2'd0;
        else                 pick = 2'd1;
      end
      default: begin
        if (req_vec[0])      pick = 2'd0;
        else if (req_vec[1]) pick = 2'd1;
        else                 pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_len  = mrd0_len;
    win_addr = mrd0_addr;
    case (pick)
      2'd1: begin
        win_len  = mrd1_len;
        win_addr = mrd1_addr;
      end
      2'd2: begin
        win_len  = mrd2_len;
        win_addr = mrd2_addr;
      end
      default: begin
        win_len  = mrd0_len;
        win_addr = mrd0_addr;
      end
    endcase
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    free_idx = 5'd0;
    for (int i = C_TAG_NUM - 1; i >= 0; i--) begin
      if (!tag_busy[i]) free_idx = 5'(i);
    end
  end

  always_comb begin
    alloc_vec = '0;
    rel_vec   = '0;
    for (int i = 0; i < C_TAG_NUM; i++) begin
      alloc_vec[i] = alloc && (free_idx == 5'(i));
      rel_vec[i]   = cpl_done && (cpl_done_tag == 8'(i)) && tag_busy[i];
    end
  end

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      tag_busy     <= '0;
      tag_free_cnt <= 6'(C_TAG_NUM);
      tag_err      <= 1'b0;
    end else begin
      // An allocated tag was free, so it never collides with a released one.
      tag_busy <= (tag_busy | alloc_vec) & ~rel_vec;
      case ({alloc, rel_valid})
        2'b10:   tag_free_cnt <= tag_free_cnt - 6'd1;
        2'b01:   tag_free_cnt <= tag_free_cnt + 6'd1;
        default: tag_free_cnt <= tag_free_cnt;
      endcase
      if (cpl_done && !rel_valid) tag_err <= 1'b1;
    end
  end

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      state       <= S_IDLE;
      rr_ptr      <= 2'd0;
      winner      <= 2'd0;
      ack_vec     <= 3'd0;
      mrd_ack_tag <= 8'd0;
      tx_mrd_req  <= 1'b0;
      tx_mrd_tag  <= 8'd0;
      tx_mrd_len  <= '0;
      tx_mrd_addr <= '0;
    end else begin
      ack_vec <= 3'd0;
      case (state)
        S_IDLE: begin
          if (alloc) begin
            state       <= S_ISSUE;
            winner      <= pick;
            tx_mrd_req  <= 1'b1;
            tx_mrd_tag  <= {3'b000, free_idx};
            tx_mrd_len  <= win_len;
            tx_mrd_addr <= win_addr;
          end
        end
        S_ISSUE: begin
          if (tx_mrd_req_ack) begin
            state       <= S_ACK;
            tx_mrd_req  <= 1'b0;
            ack_vec     <= 3'b001 << winner;
            mrd_ack_tag <= tx_mrd_tag;
            rr_ptr      <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PCIE_TX_MRD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      to_cnt        <= '0;
      issue_timeout <= 1'b0;
    end else if (state != S_ISSUE) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != TW'(C_TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TW'(C_TIMEOUT_CYCLES - 1)) issue_timeout <= 1'b1;
    end
  end
`else
  assign issue_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
